// File: rtl/multi_edge_detector_pkg.sv
// rtl/multi_edge_detector_pkg.sv - shared constants and helpers for the multi-channel edge detector
//
// Purpose : edge-mode encodings and the debounce counter width helper used by
//           edge_channel and multi_edge_detector.
// Contents: MODE_OFF / MODE_RISE / MODE_FALL / MODE_BOTH, dbc_width().

package multi_edge_detector_pkg;

   localparam logic [1:0] MODE_OFF  = 2'b00;
   localparam logic [1:0] MODE_RISE = 2'b01;
   localparam logic [1:0] MODE_FALL = 2'b10;
   localparam logic [1:0] MODE_BOTH = 2'b11;

   // Width needed to hold the values 0..cycles, never narrower than one bit.
   function automatic int dbc_width(input int cycles);
      int w;
      w = $clog2(cycles + 1);
      if (w < 1) begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/multi_edge_detector_edge_channel.sv
// rtl/multi_edge_detector_edge_channel.sv - one channel: synchroniser, debounce, edge qualify, sticky flag
//
// Purpose : conditions one asynchronous input and reports qualified edges.
// Optional: EDGE_COUNTER_EN adds a saturating per-channel event counter.
// Ports   :
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   i_signal       asynchronous input level
//   i_mode         edge mode (off / rise / fall / both)
//   i_flag_clr     write-1-to-clear strobe for the sticky flag (and counter)
//   o_edge_pulse   one-cycle pulse per qualified edge
//   o_event_flag   sticky event indication
//   o_event_count  saturating edge count (EDGE_COUNTER_EN only)

module edge_channel
   import multi_edge_detector_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 0,
   parameter bit INIT_LEVEL      = 1'b0
`ifdef EDGE_COUNTER_EN
   ,
   parameter int CNT_W           = 8
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_signal,
   input  logic [1:0]       i_mode,
   input  logic             i_flag_clr,
   output logic             o_edge_pulse,
   output logic             o_event_flag
`ifdef EDGE_COUNTER_EN
   ,
   output logic [CNT_W-1:0] o_event_count
`endif
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_filtered;
   logic                   r_edge_pulse;
   logic                   r_event_flag;
   logic                   w_synced;
   logic                   w_accept;
   logic                   w_rise;
   logic                   w_fall;
   logic                   w_rise_en;
   logic                   w_fall_en;
   logic                   w_pulse_next;

   assign w_synced = r_sync[SYNC_STAGES-1];

   // Synchroniser chain and filtered level share one reset value so that a
   // channel held at INIT_LEVEL produces no edge on reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync     <= {SYNC_STAGES{INIT_LEVEL}};
         r_filtered <= INIT_LEVEL;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_signal};
         if (w_accept) begin
            r_filtered <= w_synced;
         end
      end
   end

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         assign w_accept = w_synced ^ r_filtered;
      end else begin : g_debounce
         localparam int               DBC_W   = dbc_width(DEBOUNCE_CYCLES);
         localparam logic [DBC_W-1:0] DBC_MAX = DBC_W'(DEBOUNCE_CYCLES);

         logic [DBC_W-1:0] r_dbc_cnt;

         // Counts consecutive cycles of disagreement; the change is taken on
         // the cycle after the count has reached DEBOUNCE_CYCLES, so any
         // return to the filtered level before then discards the attempt.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_dbc_cnt <= '0;
            end else if ((w_synced == r_filtered) || (r_dbc_cnt == DBC_MAX)) begin
               r_dbc_cnt <= '0;
            end else begin
               r_dbc_cnt <= r_dbc_cnt + DBC_W'(1);
            end
         end

         assign w_accept = (w_synced != r_filtered) && (r_dbc_cnt == DBC_MAX);
      end
   endgenerate

   // w_accept implies the new level is w_synced and the old one its inverse.
   assign w_rise       = w_accept & w_synced;
   assign w_fall       = w_accept & ~w_synced;
   assign w_rise_en    = (i_mode == MODE_RISE) | (i_mode == MODE_BOTH);
   assign w_fall_en    = (i_mode == MODE_FALL) | (i_mode == MODE_BOTH);
   assign w_pulse_next = (w_rise & w_rise_en) | (w_fall & w_fall_en);

   // A new pulse dominates a coincident clear so no event is ever lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_edge_pulse <= 1'b0;
         r_event_flag <= 1'b0;
      end else begin
         r_edge_pulse <= w_pulse_next;
         r_event_flag <= w_pulse_next | (r_event_flag & ~i_flag_clr);
      end
   end

   assign o_edge_pulse = r_edge_pulse;
   assign o_event_flag = r_event_flag;

`ifdef EDGE_COUNTER_EN
   logic [CNT_W-1:0] r_event_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_event_count <= '0;
      end else if (i_flag_clr) begin
         r_event_count <= CNT_W'(w_pulse_next);
      end else if (w_pulse_next && (r_event_count != {CNT_W{1'b1}})) begin
         r_event_count <= r_event_count + CNT_W'(1);
      end
   end

   assign o_event_count = r_event_count;
`endif

endmodule

// File: rtl/multi_edge_detector.sv
// rtl/multi_edge_detector.sv - multi-channel edge detector with sticky flags and maskable irq
//
// Purpose : NUM_CH independent edge_channel instances plus the registered
//           interrupt reduction.
// Optional: EDGE_COUNTER_EN adds the event_count port and per-channel counters.
// Ports   :
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   signal_in    asynchronous inputs, bit i = channel i
//   edge_mode    per-channel mode, bits [2i+1:2i]
//   flag_clr     write-1-to-clear strobes for event_flag
//   irq_en       per-channel interrupt enable
//   edge_pulse   one-cycle pulse per qualified edge
//   event_flag   sticky event indication
//   irq          registered OR of (event_flag & irq_en)
//   event_count  per-channel counts, CNT_W bits each (EDGE_COUNTER_EN only)

module multi_edge_detector
   import multi_edge_detector_pkg::*;
#(
   parameter int NUM_CH          = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 0,
   parameter bit INIT_LEVEL      = 1'b0,
   parameter int CNT_W           = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CH-1:0]       signal_in,
   input  logic [2*NUM_CH-1:0]     edge_mode,
   input  logic [NUM_CH-1:0]       flag_clr,
   input  logic [NUM_CH-1:0]       irq_en,
   output logic [NUM_CH-1:0]       edge_pulse,
   output logic [NUM_CH-1:0]       event_flag,
   output logic                    irq
`ifdef EDGE_COUNTER_EN
   ,
   output logic [NUM_CH*CNT_W-1:0] event_count
`endif
);

   logic [NUM_CH-1:0] w_event_flag;
   logic              r_irq;

   generate
      for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
         edge_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INIT_LEVEL      (INIT_LEVEL)
`ifdef EDGE_COUNTER_EN
            ,
            .CNT_W           (CNT_W)
`endif
         ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .i_signal      (signal_in[g]),
            .i_mode        (edge_mode[2*g +: 2]),
            .i_flag_clr    (flag_clr[g]),
            .o_edge_pulse  (edge_pulse[g]),
            .o_event_flag  (w_event_flag[g])
`ifdef EDGE_COUNTER_EN
            ,
            .o_event_count (event_count[g*CNT_W +: CNT_W])
`endif
         );
      end
   endgenerate

   // Registered so irq is glitch-free at the pin; it trails event_flag by one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= |(w_event_flag & irq_en);
      end
   end

   assign event_flag = w_event_flag;
   assign irq        = r_irq;

endmodule

// File: tb/tb_multi_edge_detector.sv
// tb/tb_multi_edge_detector.sv - self-checking bench for multi_edge_detector (D=0 and D=4 instances)

module tb_multi_edge_detector;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] signal_in;
   logic [7:0] edge_mode;
   logic [3:0] flag_clr;
   logic [3:0] irq_en;
   logic [3:0] ep0, ef0, ep4, ef4;
   logic       irq0, irq4;
`ifdef EDGE_COUNTER_EN
   logic [7:0] cnt0, cnt4;
`endif

   int tests = 0;
   int fails = 0;

   // Reference state: [0] models the D=0 instance, [1] the D=4 instance.
   // hist[k][c][0] is the newest input sample; the filter looks at the
   // window of samples that have already passed the two-stage synchroniser.
   bit hist   [2][4][8];
   bit m_lvl  [2][4];
   bit m_pulse[2][4];
   bit m_flag [2][4];
   bit m_irq  [2];
   int m_cnt  [2][4];

   always #5 clk = ~clk;

   multi_edge_detector #(.NUM_CH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .INIT_LEVEL(1'b0), .CNT_W(2)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .signal_in(signal_in), .edge_mode(edge_mode),
      .flag_clr(flag_clr), .irq_en(irq_en), .edge_pulse(ep0), .event_flag(ef0), .irq(irq0)
`ifdef EDGE_COUNTER_EN
      , .event_count(cnt0)
`endif
   );

   multi_edge_detector #(.NUM_CH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .INIT_LEVEL(1'b0), .CNT_W(2)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .signal_in(signal_in), .edge_mode(edge_mode),
      .flag_clr(flag_clr), .irq_en(irq_en), .edge_pulse(ep4), .event_flag(ef4), .irq(irq4)
`ifdef EDGE_COUNTER_EN
      , .event_count(cnt4)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_irq[k] = 1'b0;
         for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 8; j++) hist[k][c][j] = 1'b0;
            m_lvl[k][c] = 1'b0; m_pulse[k][c] = 1'b0; m_flag[k][c] = 1'b0; m_cnt[k][c] = 0;
         end
      end
   endtask

   task automatic check_all();
      logic [3:0] e_p, e_f;
      logic [7:0] e_c;
      for (int k = 0; k < 2; k++) begin
         for (int c = 0; c < 4; c++) begin
            e_p[c] = m_pulse[k][c];
            e_f[c] = m_flag[k][c];
            e_c[2*c +: 2] = 2'(m_cnt[k][c]);
         end
         chk(k ? "d4_pulse" : "d0_pulse", k ? ep4 : ep0, e_p);
         chk(k ? "d4_flag" : "d0_flag", k ? ef4 : ef0, e_f);
         chk(k ? "d4_irq" : "d0_irq", k ? irq4 : irq0, m_irq[k]);
`ifdef EDGE_COUNTER_EN
         chk(k ? "d4_count" : "d0_count", k ? cnt4 : cnt0, e_c);
`endif
      end
   endtask

   // One clock edge: advance the reference from the inputs present at the
   // edge, then compare every output 1 ns later.
   task automatic tick();
      bit acc, p, nirq;
      int d;
      @(posedge clk);
      if (rst_n) begin
         for (int k = 0; k < 2; k++) begin
            d = (k == 0) ? 0 : 4;
            nirq = 1'b0;
            for (int c = 0; c < 4; c++) if (m_flag[k][c] && irq_en[c]) nirq = 1'b1;
            for (int c = 0; c < 4; c++) begin
               // Accept a new level once D+1 consecutive synced samples disagree with it.
               acc = 1'b1;
               for (int j = 1; j <= 1 + d; j++) if (hist[k][c][j] == m_lvl[k][c]) acc = 1'b0;
               p = acc && (m_lvl[k][c] ? edge_mode[2*c+1] : edge_mode[2*c]);
               if (acc) m_lvl[k][c] = !m_lvl[k][c];
               if (flag_clr[c]) m_cnt[k][c] = p ? 1 : 0;
               else if (p && m_cnt[k][c] < 3) m_cnt[k][c]++;
               m_flag[k][c] = p || (m_flag[k][c] && !flag_clr[c]);
               m_pulse[k][c] = p;
               for (int j = 7; j > 0; j--) hist[k][c][j] = hist[k][c][j-1];
               hist[k][c][0] = signal_in[c];
            end
            m_irq[k] = nirq;
         end
      end
      #1;
      check_all();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int n_p, first0, first4;
      bit [2:0] exp_cnt [5];
      exp_cnt = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3};

      rst_n = 1'b0; signal_in = '0; edge_mode = '0; flag_clr = '0; irq_en = '0;
      model_reset();
      #2;
      chk("reset_pulse", {ep4, ep0}, 8'h00);
      chk("reset_flag", {ef4, ef0}, 8'h00);
      chk("reset_irq", {irq4, irq0}, 2'b00);
      ticks(2);
      rst_n = 1'b1;
      ticks(2);

      // Latency: D=0 pulses after edge 3, irq one cycle later.
      edge_mode = 8'b01_01_11_01;
      irq_en = 4'b0001;
      signal_in[0] = 1'b1;
      tick(); chk("lat_e1", ep0[0], 1'b0);
      tick(); chk("lat_e2", ep0[0], 1'b0);
      tick(); chk("lat_e3_pulse", ep0[0], 1'b1); chk("lat_e3_flag", ef0[0], 1'b1); chk("lat_e3_irq", irq0, 1'b0);
      tick(); chk("lat_e4_pulse", ep0[0], 1'b0); chk("lat_e4_irq", irq0, 1'b1);
      ticks(10);

      // Both-edge mode on ch1, then the same stimulus with mode off.
      signal_in[1] = 1'b1; ticks(10);
      n_p = 0;
      signal_in[1] = 1'b0;
      for (int i = 0; i < 5; i++) begin tick(); n_p += ep0[1]; end
      signal_in[1] = 1'b1;
      for (int i = 0; i < 10; i++) begin tick(); n_p += ep0[1]; end
      chk("both_mode_pulses", n_p, 2);
      edge_mode[3:2] = 2'b00;
      n_p = 0;
      signal_in[1] = 1'b0;
      for (int i = 0; i < 5; i++) begin tick(); n_p += ep0[1]; end
      signal_in[1] = 1'b1;
      for (int i = 0; i < 10; i++) begin tick(); n_p += ep0[1]; end
      chk("off_mode_pulses", n_p, 0);

      // D=4: a 3-cycle glitch is rejected, a 6-cycle high is taken at edge 7.
      n_p = 0;
      signal_in[2] = 1'b1; ticks(3);
      signal_in[2] = 1'b0;
      for (int i = 0; i < 12; i++) begin tick(); n_p += ep4[2]; end
      chk("d4_glitch_pulses", n_p, 0);
      first4 = 0;
      signal_in[2] = 1'b1;
      for (int i = 1; i <= 6; i++) begin tick(); if (ep4[2] && first4 == 0) first4 = i; end
      signal_in[2] = 1'b0;
      for (int i = 7; i <= 12; i++) begin tick(); if (ep4[2] && first4 == 0) first4 = i; end
      chk("d4_latency", first4, 7);
      ticks(12);

      // Flag: set wins over a coincident clear; a lone clear drops flag then irq.
      irq_en = 4'b1000;
      signal_in[3] = 1'b1; ticks(12);
      chk("flag3_set", ef0[3], 1'b1);
      signal_in[3] = 1'b0; ticks(12);
      signal_in[3] = 1'b1; ticks(2);
      flag_clr[3] = 1'b1; tick(); flag_clr[3] = 1'b0;
      chk("flag3_set_wins_pulse", ep0[3], 1'b1);
      chk("flag3_set_wins", ef0[3], 1'b1);
      ticks(10);
      flag_clr[3] = 1'b1; tick(); flag_clr[3] = 1'b0;
      chk("flag3_cleared", ef0[3], 1'b0);
      tick(); chk("irq_after_clear", irq0, 1'b0);

      // Reset in the middle of a D=4 debounce, input still high afterwards.
      signal_in[2] = 1'b0; ticks(12);
      signal_in[2] = 1'b1; ticks(4);
      rst_n = 1'b0; model_reset(); #1;
      chk("midrst_pulse", {ep4, ep0}, 8'h00);
      chk("midrst_flag", {ef4, ef0}, 8'h00);
      chk("midrst_irq", {irq4, irq0}, 2'b00);
      tick();
      rst_n = 1'b1;
      first0 = 0; first4 = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (ep0[2] && first0 == 0) first0 = i;
         if (ep4[2] && first4 == 0) first4 = i;
      end
      chk("release_latency_d0", first0, 3);
      chk("release_latency_d4", first4, 7);

      // Five rising edges on ch0 with CNT_W=2 saturate at 3, then a clear.
      edge_mode[1:0] = 2'b01;
      signal_in[0] = 1'b0; ticks(12);
      flag_clr = 4'hF; tick(); flag_clr = 4'h0;
      for (int e = 0; e < 5; e++) begin
         signal_in[0] = 1'b1; ticks(3);
`ifdef EDGE_COUNTER_EN
         chk("count_sat", cnt0[1:0], exp_cnt[e][1:0]);
`else
         chk("count_edge_pulse", ep0[0], 1'b1);
`endif
         signal_in[0] = 1'b0; ticks(3);
      end
      flag_clr[0] = 1'b1; tick(); flag_clr[0] = 1'b0;
`ifdef EDGE_COUNTER_EN
      chk("count_cleared", cnt0[1:0], 2'b00);
`else
      chk("flag0_cleared", ef0[0], 1'b0);
`endif

      // Randomised traffic with occasional mode/enable changes and resets.
      for (int i = 0; i < 600; i++) begin
         for (int c = 0; c < 4; c++) if ($urandom_range(5) == 0) signal_in[c] = ~signal_in[c];
         if ($urandom_range(15) == 0) edge_mode = 8'($urandom);
         if ($urandom_range(15) == 0) irq_en = 4'($urandom);
         flag_clr = ($urandom_range(5) == 0) ? 4'($urandom) : 4'h0;
         if ($urandom_range(199) == 0) begin
            rst_n = 1'b0; model_reset(); #1;
            check_all();
            tick();
            rst_n = 1'b1;
         end
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/multi_edge_detector.md
Name: multi_edge_detector

Overview:
- Multi-channel, parametrised edge detector for asynchronous external inputs such as buttons, sensor strobes and GPIO.
- Per channel: synchroniser, optional debounce filter, per-channel edge-mode select (rise/fall/both/off), one-cycle edge pulse and a sticky event flag.
- Aggregated, maskable interrupt output.
- Sits between top-level pins and control logic/register file; replaces single-channel rise/fall detectors.

Parameters:
- NUM_CH, 4, number of independent input channels (1..32).
- SYNC_STAGES, 2, synchroniser flops per channel (2..4).
- DEBOUNCE_CYCLES, 0, consecutive stable cycles required before a level change is accepted; 0 = filter bypassed.
- INIT_LEVEL, 0, reset value of each channel's filtered level (all channels same).
- CNT_W, 8, event counter width (used only with EDGE_COUNTER_EN).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- signal_in  in  NUM_CH  asynchronous inputs, bit i = channel i
- edge_mode  in  2*NUM_CH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
- flag_clr  in  NUM_CH  write-1-to-clear for event_flag (single-cycle strobe)
- irq_en  in  NUM_CH  per-channel interrupt enable
- edge_pulse  out  NUM_CH  one-cycle pulse per qualified edge
- event_flag  out  NUM_CH  sticky event indication
- irq  out  1  registered OR of (event_flag & irq_en)
- event_count  out  NUM_CH*CNT_W  per-channel counts (only with EDGE_COUNTER_EN)

Behaviour:
- Reset (rst_n low, asynchronous):
  - Synchroniser flops and filtered level are set to INIT_LEVEL.
  - Debounce counters are set to 0.
  - edge_pulse, event_flag, irq and event_count are set to 0.
- Synchroniser: SYNC_STAGES-deep shift chain per channel. Its last stage is the "synced" value.
- Filter with DEBOUNCE_CYCLES = 0: filtered <= synced every cycle.
- Filter with DEBOUNCE_CYCLES = D > 0:
  - The counter increments while synced != filtered.
  - The counter resets to 0 whenever synced == filtered. A glitch shorter than D cycles is therefore rejected.
  - On the edge where the count would reach D: filtered <= synced and the counter returns to 0.
- Edge qualification is evaluated on the same edge that filtered changes, using the old vs new filtered value:
  - rise = old 0, new 1.
  - fall = old 1, new 0.
  - edge_pulse[i] <= (rise & mode[0]) | (fall & mode[1]).
- Latency: a level change first sampled at clock edge 1 gives edge_pulse high for exactly one cycle after edge SYNC_STAGES+1+D. With SYNC_STAGES=2 and D=0 that is after edge 3.
- Consecutive edges at least one cycle apart produce separate pulses. A pulse never exceeds one cycle.
- Mode 00: no pulse; the filter still tracks the input.
- Changing edge_mode never generates a pulse by itself. The new mode applies from the next qualified transition.
- Release after reset: if an input is already at !INIT_LEVEL when reset releases, the corresponding edge fires after the normal latency. This is intended; software masks it via flag_clr.
- event_flag[i]:
  - Set when edge_pulse[i] is registered high. Visible in the same cycle as the pulse.
  - Cleared by flag_clr[i]. Simultaneous set and clear: set wins.
- irq <= |(event_flag & irq_en), one cycle after event_flag. Clearing irq_en deasserts irq on the next edge.
- Channels are fully independent; there are no cross-channel priority or ordering rules.

Optional Feature:
- Macro: EDGE_COUNTER_EN.
- Defined:
  - Adds event_count, one CNT_W-bit counter per channel.
  - Increments on each edge_pulse and saturates at all-ones.
  - flag_clr[i] also clears count i. Simultaneous pulse and clear gives count = 1.
  - Counter is reset to 0.
- Undefined: the event_count port and counters are absent; all other behaviour is identical.

Decomposition:
- Package multi_edge_detector_pkg contains:
  - edge-mode localparams MODE_OFF=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10, MODE_BOTH=2'b11;
  - a function returning the debounce counter width, clog2(DEBOUNCE_CYCLES+1) with a minimum of 1.
- Sub-module edge_channel: synchroniser, filter, qualification, flag and optional counter for one channel. It is instantiated NUM_CH times in a generate loop.
- The top level holds only the irq reduction and register.

Test Plan:
- NUM_CH=4, SYNC=2, D=0, mode ch0=01: drive ch0 0->1 before edge 1 -> edge_pulse[0] high exactly one cycle after edge 3, event_flag[0]=1, irq=1 one cycle later with irq_en[0]=1.
- mode=11 on ch1: 1->0 then 0->1, each held 5 cycles -> two single-cycle pulses 5 cycles apart; mode=00 with the same stimulus -> no pulse.
- D=4: 3-cycle high glitch on ch2 -> no pulse; 6-cycle high -> one pulse at latency 2+1+4=7 edges.
- event_flag[3] set, flag_clr[3] asserted in the same cycle as a new pulse -> flag stays 1; a later flag_clr alone -> flag 0, irq 0 the next cycle.
- rst_n asserted mid-debounce (counter=2) -> all outputs 0 immediately; after release the input still high -> pulse after full latency from release.
- EDGE_COUNTER_EN, CNT_W=2: 5 rising edges on ch0 -> event_count[0] reads 1,2,3,3,3 (saturates); flag_clr[0] -> 0.
